// File: rtl/neuron_feeder_pkg.sv
// Shared types and default widths for the neuron feeder sequencer.
// No logic: enum, widths and pipeline depth only.
// Imported by the feeder top and its feed pipeline.
package neuron_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4,
    ST_WAIT   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  localparam int DEF_DATA_WIDTH       = 24;
  localparam int DEF_ADDR_DEPTH       = 12;
  localparam int DEF_WEIGHT_PERCISION = 5;
  localparam int DEF_WEIGHT_WORD      = 3 * DEF_WEIGHT_PERCISION;

  // Cycles from read issue to the calculator enable strobe.
  localparam int FEED_LAT = 2;

endpackage

// File: rtl/neuron_feeder_feed_pipe.sv
// Read/feed pipeline: tracks in-flight RAM reads and registers pixel/weights.
// Latency: issue in cycle t -> calc_enable with x_out/w_out in cycle t+FEED_LAT.
// Backpressure: none here; the sequencer gates issue, in-flight reads always complete.
module neuron_feeder_feed_pipe
  import neuron_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WGT_WIDTH  = DEF_WEIGHT_WORD
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue,
  input  logic [DATA_WIDTH-1:0] img_data,
  input  logic [WGT_WIDTH-1:0]  wgt_data,
  output logic [DATA_WIDTH-1:0] x_out,
  output logic [WGT_WIDTH-1:0]  w_out,
  output logic                  calc_enable,
  output logic                  empty
);

  // vld_q[0]: RAM data valid this cycle; vld_q[FEED_LAT-1]: feed valid.
  logic [FEED_LAT-1:0]   vld_q, vld_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [WGT_WIDTH-1:0]  w_q, w_d;

  // Shift valid bits; capture RAM data only when it belongs to an issued read.
  always_comb begin
    vld_d = {vld_q[FEED_LAT-2:0], issue};
    x_d   = x_q;
    w_d   = w_q;
    if (vld_q[FEED_LAT-2]) begin
      x_d = img_data;
      w_d = wgt_data;
    end
  end

  // Pipeline registers; data holds its last value between strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      x_q   <= '0;
      w_q   <= '0;
    end else begin
      vld_q <= vld_d;
      x_q   <= x_d;
      w_q   <= w_d;
    end
  end

  assign x_out       = x_q;
  assign w_out       = w_q;
  assign calc_enable = vld_q[FEED_LAT-1];
  assign empty       = ~|vld_q;

endmodule

// File: rtl/neuron_feeder.sv
// Sequencer: clears the neuron calculator, streams NUM_PIXELS pixel/weight pairs, captures the decision.
// Latency: done in cycle NUM_PIXELS+5+RESULT_LATENCY after start (plus one per hold cycle in RUN).
// Backpressure: hold stalls new RAM reads only; start outside IDLE is dropped, never queued.
module neuron_feeder
  import neuron_feeder_pkg::*;
#(
  parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
  parameter int Addr_Depth       = DEF_ADDR_DEPTH,
  parameter int Weight_Percision = DEF_WEIGHT_PERCISION,
  parameter int NUM_PIXELS       = 4096,
  parameter int RESULT_LATENCY   = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          hold,
  output logic [Addr_Depth-1:0]         mem_addr,
  output logic                          mem_rd_en,
  input  logic [DATA_WIDTH-1:0]         img_data,
  input  logic [3*Weight_Percision-1:0] wgt_data,
  output logic [DATA_WIDTH-1:0]         x_out,
  output logic [3*Weight_Percision-1:0] w_out,
  output logic                          calc_clear,
  output logic                          calc_enable,
  output logic                          calc_get_result,
  input  logic                          calc_out,
  output logic                          busy,
  output logic                          done,
  output logic                          cat_detected
);

  localparam int WW  = 3 * Weight_Percision;
  localparam int WCW = $clog2(RESULT_LATENCY + 1);
  // One extra bit so NUM_PIXELS == 2**Addr_Depth still compares correctly.
  localparam logic [Addr_Depth:0] PIX_END   = (Addr_Depth + 1)'(NUM_PIXELS);
  localparam logic [WCW-1:0]      WAIT_LAST = WCW'(RESULT_LATENCY - 1);
  localparam logic [WCW-1:0]      DRAIN_LAST = WCW'(FEED_LAT - 1);

  state_e                state_q, state_d;
  logic [Addr_Depth-1:0] cnt_q, cnt_d;
  logic [Addr_Depth:0]   cnt_inc;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  cat_q, cat_d;
  logic                  issue;
  logic                  pipe_empty;

  // Next-state, address counter, phase counter (DRAIN/WAIT) and decision capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    cat_d   = cat_q;
    issue   = 1'b0;
    cnt_inc = {1'b0, cnt_q} + (Addr_Depth + 1)'(1);
    case (state_q)
      ST_IDLE: begin
        // Pipeline is always drained by IDLE; the guard keeps a stale feed
        // from ever mixing into a new image.
        if (start && pipe_empty) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!hold) begin
          issue = 1'b1;
          if (cnt_inc == PIX_END) begin
            // Counter parks on the last address instead of wrapping.
            wcnt_d  = '0;
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_inc[Addr_Depth-1:0];
          end
        end
      end
      ST_DRAIN: begin
        // Lets the last issued read reach calc_enable before asking for the result.
        if (wcnt_q == DRAIN_LAST) begin
          wcnt_d  = '0;
          state_d = ST_RESULT;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      ST_RESULT: begin
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          cat_d   = calc_out;
          state_d = ST_DONE;
        end else begin
          wcnt_d = wcnt_q + WCW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      cat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      cat_q   <= cat_d;
    end
  end

  neuron_feeder_feed_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .WGT_WIDTH  (WW)
  ) u_feed_pipe (
    .clock       (clock),
    .reset       (reset),
    .issue       (issue),
    .img_data    (img_data),
    .wgt_data    (wgt_data),
    .x_out       (x_out),
    .w_out       (w_out),
    .calc_enable (calc_enable),
    .empty       (pipe_empty)
  );

  assign mem_rd_en       = issue;
  assign mem_addr        = cnt_q;
  assign calc_clear      = (state_q == ST_CLEAR);
  assign calc_get_result = (state_q == ST_RESULT);
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign cat_detected    = cat_q;

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench: DUT a (NUM_PIXELS=4, RESULT_LATENCY=1) and DUT b (NUM_PIXELS=1, RESULT_LATENCY=3).
// Cycle k counts from the start-sampling edge 0; CLEAR is cycle 1.
// RAMs are modelled as one-cycle registered reads from small constant tables.
module tb_neuron_feeder;
  import neuron_feeder_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int AW = DEF_ADDR_DEPTH;
  localparam int WW = DEF_WEIGHT_WORD;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // DUT a signals
  logic          start = 1'b0, hold = 1'b0, calc_out = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, calc_clear, calc_enable, calc_get_result, busy, done, cat_detected;
  logic [DW-1:0] img_data = '0, x_out;
  logic [WW-1:0] wgt_data = '0, w_out;

  // DUT b signals
  logic          start_b = 1'b0, hold_b = 1'b0, calc_out_b = 1'b0;
  logic [AW-1:0] mem_addr_b;
  logic          mem_rd_en_b, calc_clear_b, calc_enable_b, calc_get_result_b, busy_b, done_b, cat_detected_b;
  logic [DW-1:0] img_data_b = '0, x_out_b;
  logic [WW-1:0] wgt_data_b = '0, w_out_b;

  neuron_feeder #(.NUM_PIXELS(4), .RESULT_LATENCY(1)) dut (
    .clock(clock), .reset(reset), .start(start), .hold(hold),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .img_data(img_data), .wgt_data(wgt_data),
    .x_out(x_out), .w_out(w_out), .calc_clear(calc_clear), .calc_enable(calc_enable),
    .calc_get_result(calc_get_result), .calc_out(calc_out), .busy(busy), .done(done),
    .cat_detected(cat_detected));

  neuron_feeder #(.NUM_PIXELS(1), .RESULT_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .hold(hold_b),
    .mem_addr(mem_addr_b), .mem_rd_en(mem_rd_en_b), .img_data(img_data_b), .wgt_data(wgt_data_b),
    .x_out(x_out_b), .w_out(w_out_b), .calc_clear(calc_clear_b), .calc_enable(calc_enable_b),
    .calc_get_result(calc_get_result_b), .calc_out(calc_out_b), .busy(busy_b), .done(done_b),
    .cat_detected(cat_detected_b));

  // Image/weight tables (distinct non-zero entries)
  logic [DW-1:0] img_mem [16];
  logic [WW-1:0] wgt_mem [16];

  always @(posedge clock) begin
    if (mem_rd_en) begin
      img_data <= img_mem[mem_addr[3:0]];
      wgt_data <= wgt_mem[mem_addr[3:0]];
    end
    if (mem_rd_en_b) begin
      img_data_b <= img_mem[mem_addr_b[3:0]];
      wgt_data_b <= wgt_mem[mem_addr_b[3:0]];
    end
  end

  int abs_cyc = 0;
  always @(posedge clock) abs_cyc <= abs_cyc + 1;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Event log for DUT a, indexed by relative cycle
  int            base   = 0;
  bit            mon_on = 1'b0;
  int            rd_cyc[$];
  logic [AW-1:0] rd_addr[$];
  int            en_cyc[$];
  logic [DW-1:0] en_x[$];
  logic [WW-1:0] en_w[$];
  int            gr_cyc[$];
  int            done_cyc[$];
  logic          done_cat[$];
  int            clr_cyc[$];
  logic          busy_log[64];
  logic          cat_log[64];

  always @(negedge clock) begin : mon_a
    int cur;
    if (mon_on) begin
      cur = abs_cyc - base;
      if (mem_rd_en)       begin rd_cyc.push_back(cur); rd_addr.push_back(mem_addr); end
      if (calc_enable)     begin en_cyc.push_back(cur); en_x.push_back(x_out); en_w.push_back(w_out); end
      if (calc_get_result) gr_cyc.push_back(cur);
      if (done)            begin done_cyc.push_back(cur); done_cat.push_back(cat_detected); end
      if (calc_clear)      clr_cyc.push_back(cur);
      if (cur >= 0 && cur < 64) begin
        busy_log[cur] = busy;
        cat_log[cur]  = cat_detected;
      end
    end
  end

  // Pulse start on DUT a; returns 1 time unit after edge 0 (inside cycle 1).
  task automatic start_a();
    mon_on = 1'b0;
    @(negedge clock);
    rd_cyc.delete(); rd_addr.delete(); en_cyc.delete(); en_x.delete(); en_w.delete();
    gr_cyc.delete(); done_cyc.delete(); done_cat.delete(); clr_cyc.delete();
    for (int i = 0; i < 64; i++) begin busy_log[i] = 1'bx; cat_log[i] = 1'bx; end
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    base   = abs_cyc - 1;
    mon_on = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #20;
    chk_cnt++;
    if ({mem_addr, mem_rd_en, x_out, w_out, calc_clear, calc_enable, calc_get_result, busy, done, cat_detected} !== '0)
      $display("FAIL reset_outputs_a: got %0h required 0",
               {mem_addr, mem_rd_en, x_out, w_out, calc_clear, calc_enable, calc_get_result, busy, done, cat_detected});
    else pass_cnt++;
    chk_cnt++;
    if ({mem_addr_b, mem_rd_en_b, x_out_b, w_out_b, calc_clear_b, calc_enable_b, calc_get_result_b, busy_b, done_b, cat_detected_b} !== '0)
      $display("FAIL reset_outputs_b: got %0h required 0",
               {mem_addr_b, mem_rd_en_b, x_out_b, w_out_b, calc_clear_b, calc_enable_b, calc_get_result_b, busy_b, done_b, cat_detected_b});
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  // N=4, RL=1: reads 2..5, enables 4..7, result 8, done 10, decision 1
  task automatic test_basic();
    calc_out = 1'b1;
    start_a();
    repeat (14) @(negedge clock);
    chk_cnt++;
    if (clr_cyc.size() != 1 || clr_cyc[0] != 1) $display("FAIL basic_clear: got %0d pulses first %0d required 1 at cycle 1", clr_cyc.size(), (clr_cyc.size() > 0) ? clr_cyc[0] : -1);
    else pass_cnt++;
    chk_cnt++;
    if (rd_cyc.size() != 4) $display("FAIL basic_read_count: got %0d required 4", rd_cyc.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < rd_cyc.size(); i++) begin
      chk_cnt++;
      if (rd_addr[i] !== AW'(i) || rd_cyc[i] != 2 + i)
        $display("FAIL basic_read%0d: got addr %0d cycle %0d required addr %0d cycle %0d", i, rd_addr[i], rd_cyc[i], i, 2 + i);
      else pass_cnt++;
    end
    chk_cnt++;
    if (en_cyc.size() != 4) $display("FAIL basic_enable_count: got %0d required 4", en_cyc.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < en_cyc.size(); i++) begin
      chk_cnt++;
      if (en_cyc[i] != 4 + i || en_x[i] !== img_mem[i] || en_w[i] !== wgt_mem[i])
        $display("FAIL basic_feed%0d: got cycle %0d x %0h w %0h required cycle %0d x %0h w %0h",
                 i, en_cyc[i], en_x[i], en_w[i], 4 + i, img_mem[i], wgt_mem[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (gr_cyc.size() != 1 || gr_cyc[0] != 8) $display("FAIL basic_get_result: got %0d pulses first %0d required 1 at cycle 8", gr_cyc.size(), (gr_cyc.size() > 0) ? gr_cyc[0] : -1);
    else pass_cnt++;
    chk_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != 10) $display("FAIL basic_done: got %0d pulses first %0d required 1 at cycle 10", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    else pass_cnt++;
    chk_cnt++;
    if (cat_log[9] !== 1'b0 || cat_log[10] !== 1'b1) $display("FAIL basic_cat: got %b->%b required 0->1", cat_log[9], cat_log[10]);
    else pass_cnt++;
    chk_cnt++;
    if (x_out !== img_mem[3] || w_out !== wgt_mem[3]) $display("FAIL basic_hold_last: got x %0h w %0h required x %0h w %0h", x_out, w_out, img_mem[3], wgt_mem[3]);
    else pass_cnt++;
  endtask

  // Second image with decision 0: cat_detected keeps 1 until that done
  task automatic test_decision();
    calc_out = 1'b0;
    start_a();
    repeat (14) @(negedge clock);
    chk_cnt++;
    if (cat_log[2] !== 1'b1 || cat_log[9] !== 1'b1) $display("FAIL decision_held: got %b,%b required 1,1", cat_log[2], cat_log[9]);
    else pass_cnt++;
    chk_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != 10 || done_cat[0] !== 1'b0)
      $display("FAIL decision_update: got %0d dones first cycle %0d required 1 at cycle 10 with cat 0", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    else pass_cnt++;
  endtask

  // hold during cycles 3..5: reads 2,6,7,8; enables 4,8,9,10; done 13
  task automatic test_hold();
    int exp_rd[4] = '{2, 6, 7, 8};
    int exp_en[4] = '{4, 8, 9, 10};
    calc_out = 1'b1;
    start_a();
    repeat (2) @(posedge clock);
    #1 hold = 1'b1;
    repeat (3) @(posedge clock);
    #1 hold = 1'b0;
    repeat (14) @(negedge clock);
    chk_cnt++;
    if (rd_cyc.size() != 4 || en_cyc.size() != 4) $display("FAIL hold_counts: got reads %0d enables %0d required 4 4", rd_cyc.size(), en_cyc.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < rd_cyc.size() && i < en_cyc.size(); i++) begin
      chk_cnt++;
      if (rd_addr[i] !== AW'(i) || rd_cyc[i] != exp_rd[i] || en_cyc[i] != exp_en[i] || en_x[i] !== img_mem[i])
        $display("FAIL hold_beat%0d: got addr %0d rd %0d en %0d x %0h required addr %0d rd %0d en %0d x %0h",
                 i, rd_addr[i], rd_cyc[i], en_cyc[i], en_x[i], i, exp_rd[i], exp_en[i], img_mem[i]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != 13) $display("FAIL hold_done: got %0d pulses first %0d required 1 at cycle 13", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    else pass_cnt++;
  endtask

  // start in cycle 3 (RUN) and cycle 10 (DONE) must both be dropped
  task automatic test_start_ignored();
    calc_out = 1'b1;
    start_a();
    repeat (2) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (6) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (20) @(negedge clock);
    chk_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != 10) $display("FAIL ignore_done: got %0d pulses first %0d required 1 at cycle 10", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    else pass_cnt++;
    chk_cnt++;
    if (busy_log[10] !== 1'b1 || busy_log[11] !== 1'b0 || busy !== 1'b0) $display("FAIL ignore_busy: got c10 %b c11 %b now %b required 1 0 0", busy_log[10], busy_log[11], busy);
    else pass_cnt++;
    chk_cnt++;
    if (clr_cyc.size() != 1 || en_cyc.size() != 4) $display("FAIL ignore_restart: got clears %0d enables %0d required 1 4", clr_cyc.size(), en_cyc.size());
    else pass_cnt++;
  endtask

  // reset pulse in cycle 4 of RUN aborts; next start begins again at address 0
  task automatic test_reset_mid_run();
    calc_out = 1'b1;
    start_a();
    repeat (3) @(posedge clock);
    #1;
    chk_cnt++;
    if (calc_enable !== 1'b1 || mem_rd_en !== 1'b1) $display("FAIL midrst_pre: got en %b rd %b required 1 1", calc_enable, mem_rd_en);
    else pass_cnt++;
    #1 reset = 1'b0;
    #1;
    chk_cnt++;
    if ({mem_addr, mem_rd_en, x_out, w_out, calc_clear, calc_enable, calc_get_result, busy, done, cat_detected} !== '0)
      $display("FAIL midrst_outputs: got %0h required 0",
               {mem_addr, mem_rd_en, x_out, w_out, calc_clear, calc_enable, calc_get_result, busy, done, cat_detected});
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b1;
    repeat (12) @(negedge clock);
    chk_cnt++;
    if (done_cyc.size() != 0 || busy !== 1'b0) $display("FAIL midrst_abort: got dones %0d busy %b required 0 0", done_cyc.size(), busy);
    else pass_cnt++;
    start_a();
    repeat (14) @(negedge clock);
    chk_cnt++;
    if (clr_cyc.size() != 1 || clr_cyc[0] != 1 || rd_cyc.size() != 4 || rd_addr[0] !== '0 || rd_cyc[0] != 2)
      $display("FAIL midrst_restart: got clears %0d reads %0d first addr %0d required 1 4 0", clr_cyc.size(), rd_cyc.size(), (rd_addr.size() > 0) ? rd_addr[0] : '1);
    else pass_cnt++;
    chk_cnt++;
    if (done_cyc.size() != 1 || done_cyc[0] != 10 || done_cat[0] !== 1'b1)
      $display("FAIL midrst_done: got %0d dones first %0d required 1 at cycle 10 cat 1", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    else pass_cnt++;
  endtask

  // N=1, RL=3: read cycle 2, enable cycle 4, result 5, done 9
  task automatic test_single_pixel();
    int rd_n = 0, rd_c = -1, en_n = 0, en_c = -1, clr_n = 0, gr_c = -1, done_n = 0, done_c = -1;
    logic [AW-1:0] rd_a = '1;
    logic [DW-1:0] ex = '0;
    logic [WW-1:0] ew = '0;
    logic          dcat = 1'b0;
    calc_out_b = 1'b1;
    @(negedge clock);
    start_b = 1'b1;
    @(posedge clock);
    #1 start_b = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      if (mem_rd_en_b)       begin rd_n++; rd_c = c; rd_a = mem_addr_b; end
      if (calc_enable_b)     begin en_n++; en_c = c; ex = x_out_b; ew = w_out_b; end
      if (calc_clear_b)      clr_n++;
      if (calc_get_result_b) gr_c = c;
      if (done_b)            begin done_n++; done_c = c; dcat = cat_detected_b; end
    end
    chk_cnt++;
    if (rd_n != 1 || rd_c != 2 || rd_a !== '0) $display("FAIL single_read: got %0d reads cycle %0d addr %0d required 1 2 0", rd_n, rd_c, rd_a);
    else pass_cnt++;
    chk_cnt++;
    if (en_n != 1 || en_c != 4 || ex !== img_mem[0] || ew !== wgt_mem[0])
      $display("FAIL single_feed: got %0d enables cycle %0d x %0h w %0h required 1 4 %0h %0h", en_n, en_c, ex, ew, img_mem[0], wgt_mem[0]);
    else pass_cnt++;
    chk_cnt++;
    if (clr_n != 1 || gr_c != 5) $display("FAIL single_clear_result: got clears %0d result cycle %0d required 1 5", clr_n, gr_c);
    else pass_cnt++;
    chk_cnt++;
    if (done_n != 1 || done_c != 9 || dcat !== 1'b1 || busy_b !== 1'b0)
      $display("FAIL single_done: got %0d dones cycle %0d cat %b busy %b required 1 9 1 0", done_n, done_c, dcat, busy_b);
    else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      img_mem[i] = DW'(24'h10_2030 + i * 24'h01_0305);
      wgt_mem[i] = WW'(15'h1234 + i * 15'h0111);
    end
    test_reset();
    test_basic();
    test_decision();
    test_hold();
    test_start_ignored();
    test_reset_mid_run();
    test_single_pixel();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/neuron_feeder.md
Name: neuron_feeder

Overview:
- Sequencer stage directly upstream of the neuron calculator.
- On a start pulse it clears the calculator's accumulator, then walks the image/weight RAMs from address 0 to NUM_PIXELS-1.
- It feeds each RGB pixel and its packed 3x weight word to the calculator with an enable strobe, then requests the result.
- It captures the 1-bit decision into cat_detected and pulses done.

Parameters:
DATA_WIDTH, 24, packed RGB pixel width (3 x 8 bit).
Addr_Depth, 12, RAM address width.
Weight_Percision, 5, bits per weight; the weight word is 3*Weight_Percision.
NUM_PIXELS, 4096, pixels per image; must be >= 1 and <= 2**Addr_Depth.
RESULT_LATENCY, 1, cycles from calc_get_result until calc_out is valid (>= 1).

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request to classify one image; sampled only in IDLE.
hold  in  1  while high in RUN, no new read is issued.
mem_addr  out  Addr_Depth  shared read address for the image RAM and weight RAM.
mem_rd_en  out  1  read strobe; RAM data is valid the cycle after.
img_data  in  DATA_WIDTH  image RAM read data.
wgt_data  in  3*Weight_Percision  weight RAM read data.
x_out  out  DATA_WIDTH  registered pixel to the calculator x.
w_out  out  3*Weight_Percision  registered weights to the calculator w.
calc_clear  out  1  drives the calculator's synchronous active-high reset.
calc_enable  out  1  accumulate strobe, aligned with x_out/w_out.
calc_get_result  out  1  one-cycle result request.
calc_out  in  1  calculator decision.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when cat_detected is updated.
cat_detected  out  1  last decision, held until the next done.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: mem_addr, mem_rd_en, x_out, w_out, calc_clear, calc_enable, calc_get_result, busy, done, cat_detected.
  - Pipeline valid bits are cleared.
- Reset mid-operation aborts the image. No done is produced, and the next start restarts from address 0.
- States: IDLE, CLEAR, RUN, DRAIN, RESULT, WAIT, DONE.
  - IDLE: start=1 moves to CLEAR. start in any other state is ignored, and no request is queued.
  - CLEAR: lasts one cycle with calc_clear=1. The address counter is set to 0. Moves to RUN.
  - RUN: each cycle with hold=0, mem_rd_en=1 and mem_addr=counter, then counter increments. With hold=1, mem_rd_en=0 and counter is held. After the read of address NUM_PIXELS-1 is issued, move to DRAIN.
  - DRAIN: lasts exactly 2 cycles, then RESULT.
  - RESULT: lasts one cycle with calc_get_result=1, then WAIT.
  - WAIT: lasts RESULT_LATENCY cycles. calc_out is sampled into cat_detected at the end of the last WAIT cycle. Moves to DONE.
  - DONE: lasts one cycle with done=1, then IDLE. A start during DONE is ignored.
- Read/feed pipeline, 2 stages:
  - A read issued in cycle t returns RAM data in cycle t+1.
  - x_out/w_out are registered from that data and calc_enable=1 in cycle t+2.
  - calc_enable is high for exactly NUM_PIXELS cycles per image, each with a distinct address in ascending order.
- Hold only gates new issues; in-flight reads still complete. This produces gaps in calc_enable but no duplicates or losses. hold is ignored outside RUN.
- x_out/w_out keep their last value when calc_enable=0.
- mem_addr wraps nowhere: the counter stops at NUM_PIXELS-1. NUM_PIXELS=2**Addr_Depth must not overflow the comparison, so use an Addr_Depth+1 bit counter.
- Latency with no hold:
  - start is sampled at edge 0, and CLEAR is cycle 1.
  - RUN is cycles 2..N+1, the last calc_enable is cycle N+3, and RESULT is cycle N+4.
  - done is high in cycle N+5+RESULT_LATENCY.
  - Each hold cycle in RUN adds one cycle.

Decomposition:
- Shared package:
  - state enum, 3-bit encoding.
  - default widths DATA_WIDTH, Addr_Depth, Weight_Percision.
  - derived WEIGHT_WORD = 3*Weight_Percision.
  - pipeline depth constant FEED_LAT = 2.
- Sub-module feed_pipe holds the valid shift register plus the x/w data registers. Its ports are clock, reset, issue, img_data, wgt_data, x_out, w_out, calc_enable, empty.
- The FSM and counter stay in neuron_feeder.

Test Plan:
- Basic run, N=4, RL=1: start at cycle 0 → mem_addr 0,1,2,3 in cycles 2-5, calc_enable cycles 4-7 with x_out = RAM[0..3], calc_get_result in cycle 8, done in cycle 10.
- Decision capture, calc_out model = 1 → cat_detected=1 with done. Then a second image with calc_out=0 → cat_detected holds 1 until the second done, then becomes 0.
- hold=1 for 3 cycles mid-RUN (N=4) → exactly 4 calc_enable pulses, addresses 0-3 each once, done delayed by 3 cycles (cycle 13).
- start pulsed during RUN and again during DONE → both ignored; exactly one done; busy falls the cycle after done.
- reset low for 1 cycle during RUN → all outputs 0 immediately. A fresh start then produces calc_clear and reads from address 0 again.
- Boundary N=1, RL=3 → one read at address 0, one calc_enable in cycle 4, done in cycle 9; calc_clear high exactly 1 cycle.
